// File: rtl/pc_pkg.sv
// Shared types for the program-counter stage: FSM encoding and request priority.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package pc_pkg;

  // Two-state control FSM; FAULT is sticky until reset.
  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_FAULT = 1'b1
  } pc_state_e;

  // One action is taken per enabled cycle; the enum order doubles as the
  // priority ranking (higher value wins).
  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_INC  = 3'd1,
    REQ_JMP  = 3'd2,
    REQ_CALL = 3'd3,
    REQ_RET  = 3'd4
  } pc_req_e;

  localparam pc_req_e PC_REQ_HIGHEST = REQ_RET;
  localparam pc_req_e PC_REQ_LOWEST  = REQ_INC;

  // Collapse simultaneous requests to the single winner: ret > call > jmp > inc.
  function automatic pc_req_e pc_decode_req(input logic ret, input logic call,
                                            input logic jmp, input logic inc);
    pc_req_e req;
    req = REQ_NONE;
    if (ret)       req = REQ_RET;
    else if (call) req = REQ_CALL;
    else if (jmp)  req = REQ_JMP;
    else if (inc)  req = REQ_INC;
    return req;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Request/status bundle between the sequencer and the program-counter stage.
// Latency: n/a (wires only).
// Backpressure: none; requests are single-cycle strobes qualified by en.
//  master: drives en/inc/jmp/call/ret/target, observes pc_out and flags.
//  slave : the pc_unit side.
interface pc_unit_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             inc;
  logic             jmp;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_out;
  logic             stk_empty;
  logic             stk_full;
  logic             fault;

  modport master (
    output en, inc, jmp, call, ret, target,
    input  pc_out, stk_empty, stk_full, fault
  );

  modport slave (
    input  en, inc, jmp, call, ret, target,
    output pc_out, stk_empty, stk_full, fault
  );
endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO; the caller guarantees no push when full and no pop when empty.
// Latency: top-of-stack read is combinational; sp and flags update at the next edge.
// Backpressure: none; full_o/empty_o are advisory for the owner.
//  Ports: clk, rst_n (sync, active-low, resets sp only), push_i, pop_i,
//  data_i (value pushed), data_o (current top), full_o, empty_o (registered).
module ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;  // one extra bit so DEPTH itself is representable

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-1:0]   top_idx;
  logic             full_q, empty_q;

  assign top_idx = sp_q - SPW'(1);
  assign data_o  = mem_q[top_idx[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  always_comb begin
    sp_d = sp_q;
    if (push_i)     sp_d = sp_q + SPW'(1);
    else if (pop_i) sp_d = sp_q - SPW'(1);
  end

  // Flags are registered but decoded from the next sp so they track sp exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      sp_q    <= sp_d;
      full_q  <= (sp_d == SPW'(DEPTH));
      empty_q <= (sp_d == '0);
    end
  end

  // Contents deliberately survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (rst_n && push_i) mem_q[sp_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: inc/jmp/call/ret with an on-chip return stack and sticky fault.
// Latency: new pc_out and flags visible one cycle after the request edge.
// Backpressure: none; en=0 or FAULT silently drops requests.
//  Ports: clk, rst_n (sync, active-low), bus (pc_unit_if.slave):
//  en/inc/jmp/call/ret/target in; pc_out/stk_empty/stk_full/fault out.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_unit_if.slave   bus
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] stk_top;
  logic             push, pop;
  logic             stk_full, stk_empty;
  pc_req_e          req;

  // Modulo 2^WIDTH: FF+1 wraps to 00, both for inc and for the pushed return address.
  assign pc_plus1 = pc_q + WIDTH'(1);
  assign req      = pc_decode_req(bus.ret, bus.call, bus.jmp, bus.inc);

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_plus1),
    .data_o  (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_q == PC_RUN && bus.en) begin
      unique case (req)
        REQ_RET: begin
          if (stk_empty) state_d = PC_FAULT;
          else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end
        REQ_CALL: begin
          if (stk_full) state_d = PC_FAULT;
          else begin
            push = 1'b1;
            pc_d = bus.target;
          end
        end
        REQ_JMP:  pc_d = bus.target;
        REQ_INC:  pc_d = pc_plus1;
        default:  pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PC_RUN;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.stk_empty = stk_empty;
  assign bus.stk_full  = stk_full;
  assign bus.fault     = (state_q == PC_FAULT);

endmodule
